micro_decode_stage: RTL and testbench

- Registered, handshaked successor to the combinational opcode→micro-command lookup.
- Sits between IFU and EXU. Accepts one fetched instruction plus PC per valid/ready transfer and matches {funct3, opcode[6:2]} against a parametrised pattern/mask table.
- Emits the micro command from a one-entry pipeline register.
- Unmatched encodings do not halt the simulator. They raise a sticky illegal-instruction trap, capture the offending instruction and PC, and freeze intake.

---
 rtl/micro_decode_pkg.sv | 106 ++++++++++
 rtl/micro_lut.sv | 28 ++
 rtl/micro_decode_stage.sv | 160 ++++++++++++++++
 tb/tb_micro_decode_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_decode_pkg.sv
// micro_decode_pkg
// Shared types and constants for the micro-command decode stage:
//   - table geometry (PATTERN_LEN, MICRO_LEN, INST_NR)
//   - micro-command field codes (REGEN/PCJEN/PCREN, MWEN_*, MREN_*, IMM_TYPE_*)
//   - micro_cmd_t, lut_entry_t and the constant DECODE_TABLE
// No ports; imported by micro_lut and micro_decode_stage.
package micro_decode_pkg;

    localparam int unsigned PATTERN_LEN = 8;
    localparam int unsigned MICRO_LEN   = 10;
    localparam int unsigned INST_NR     = 9;

    // Single-bit enables
    localparam logic REGEN = 1'b1;
    localparam logic PCJEN = 1'b1;
    localparam logic PCREN = 1'b1;

    // Memory write enable codes
    localparam logic [1:0] MWEN_NONE = 2'b00;
    localparam logic [1:0] MWEN_WORD = 2'b11;

    // Memory read enable codes
    localparam logic [1:0] MREN_NONE = 2'b00;
    localparam logic [1:0] MREN_BYTE = 2'b01;
    localparam logic [1:0] MREN_HALF = 2'b10;
    localparam logic [1:0] MREN_WORD = 2'b11;

    // Immediate format codes
    localparam logic [2:0] IMM_TYPE_NONE = 3'b000;
    localparam logic [2:0] IMM_TYPE_I    = 3'b001;
    localparam logic [2:0] IMM_TYPE_S    = 3'b010;
    localparam logic [2:0] IMM_TYPE_U    = 3'b110;
    localparam logic [2:0] IMM_TYPE_J    = 3'b111;

    // Key is {funct3, opcode[6:2]}; MASK_OP ignores funct3
    localparam logic [PATTERN_LEN-1:0] MASK_OP    = 8'b000_11111;
    localparam logic [PATTERN_LEN-1:0] MASK_EXACT = 8'b111_11111;

    typedef struct packed {
        logic       regen;
        logic       pcjen;
        logic       pcren;
        logic [1:0] mwen;
        logic [1:0] mren;
        logic [2:0] imm_type;
    } micro_cmd_t;

    typedef struct packed {
        logic [PATTERN_LEN-1:0] pattern;
        logic [PATTERN_LEN-1:0] mask;
        micro_cmd_t             micro;
    } lut_entry_t;

    function automatic lut_entry_t mk_entry(
        input logic [PATTERN_LEN-1:0] pattern,
        input logic [PATTERN_LEN-1:0] mask,
        input logic                   regen,
        input logic                   pcjen,
        input logic                   pcren,
        input logic [1:0]             mwen,
        input logic [1:0]             mren,
        input logic [2:0]             imm_type
    );
        lut_entry_t e;
        e.pattern        = pattern;
        e.mask           = mask;
        e.micro.regen    = regen;
        e.micro.pcjen    = pcjen;
        e.micro.pcren    = pcren;
        e.micro.mwen     = mwen;
        e.micro.mren     = mren;
        e.micro.imm_type = imm_type;
        return e;
    endfunction

    localparam lut_entry_t DECODE_TABLE [INST_NR] = '{
        // AUIPC
        mk_entry(8'b000_00101, MASK_OP, REGEN, 1'b0, PCREN, MWEN_NONE, MREN_NONE,
                 IMM_TYPE_U),
        // JAL
        mk_entry(8'b000_11011, MASK_OP, REGEN, PCJEN, PCREN, MWEN_NONE, MREN_NONE,
                 IMM_TYPE_J),
        // JALR
        mk_entry(8'b000_11001, MASK_OP, REGEN, PCJEN, 1'b0, MWEN_NONE, MREN_NONE,
                 IMM_TYPE_I),
        // LB
        mk_entry(8'b000_00000, MASK_EXACT, REGEN, 1'b0, 1'b0, MWEN_NONE, MREN_BYTE,
                 IMM_TYPE_I),
        // LH
        mk_entry(8'b001_00000, MASK_EXACT, REGEN, 1'b0, 1'b0, MWEN_NONE, MREN_HALF,
                 IMM_TYPE_I),
        // LW
        mk_entry(8'b010_00000, MASK_EXACT, REGEN, 1'b0, 1'b0, MWEN_NONE, MREN_WORD,
                 IMM_TYPE_I),
        // SW
        mk_entry(8'b010_01000, MASK_EXACT, 1'b0, 1'b0, 1'b0, MWEN_WORD, MREN_NONE,
                 IMM_TYPE_S),
        // ADDI
        mk_entry(8'b000_00100, MASK_EXACT, REGEN, 1'b0, 1'b0, MWEN_NONE, MREN_NONE,
                 IMM_TYPE_I),
        // EBREAK
        mk_entry(8'b000_11100, MASK_EXACT, 1'b0, 1'b0, 1'b0, MWEN_NONE, MREN_NONE,
                 IMM_TYPE_NONE)
    };

endpackage

// File: rtl/micro_lut.sv
// micro_lut
// Purely combinational pattern/mask matcher over DECODE_TABLE.
// Ports:
//   i_key   in  PATTERN_LEN  {funct3, opcode[6:2]}
//   o_hit   out 1            some table entry matches
//   o_micro out micro_cmd_t  micro command of the lowest matching entry (0 on miss)
module micro_lut
    import micro_decode_pkg::*;
(
    input  logic [PATTERN_LEN-1:0] i_key,
    output logic                   o_hit,
    output micro_cmd_t             o_micro
);

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        o_hit   = 1'b0;
        o_micro = '0;
        for (int i = INST_NR - 1; i >= 0; i--) begin
            if ((i_key & DECODE_TABLE[i].mask) ==
                (DECODE_TABLE[i].pattern & DECODE_TABLE[i].mask)) begin
                o_hit   = 1'b1;
                o_micro = DECODE_TABLE[i].micro;
            end
        end
    end

endmodule

// File: rtl/micro_decode_stage.sv
// micro_decode_stage
// Registered, valid/ready decode stage between IFU and EXU. Decodes one instruction per
// transfer into a micro command held in a one-entry output register. Unmatched encodings
// raise a sticky illegal trap, capture instruction/PC and halt intake until rst.
// Optional feature: define MICRO_DECODE_PERF_EN to build the performance counters;
// otherwise perf_decoded/perf_stall are tied to 0.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         input handshake; in_inst, in_pc instruction and its PC
//   flush                     discard held output, block intake this cycle
//   out_valid/out_ready       output handshake; out_micro, out_inst, out_pc payload
//   illegal                   sticky trap flag; illegal_inst/illegal_pc captured word/PC
//   halted                    stage is in HALT
//   perf_decoded, perf_stall  hit-transfer and stall-cycle counters
module micro_decode_stage
    import micro_decode_pkg::*;
#(
    parameter int unsigned INST_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INST_W-1:0]    in_inst,
    input  logic [INST_W-1:0]    in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MICRO_LEN-1:0] out_micro,
    output logic [INST_W-1:0]    out_inst,
    output logic [INST_W-1:0]    out_pc,
    output logic                 illegal,
    output logic [INST_W-1:0]    illegal_inst,
    output logic [INST_W-1:0]    illegal_pc,
    output logic                 halted,
    output logic [CNT_W-1:0]     perf_decoded,
    output logic [CNT_W-1:0]     perf_stall
);

    typedef enum logic {StRun, StHalt} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic               r_out_valid;
    micro_cmd_t         r_out_micro;
    logic [INST_W-1:0]  r_out_inst;
    logic [INST_W-1:0]  r_out_pc;
    logic               r_illegal;
    logic [INST_W-1:0]  r_illegal_inst;
    logic [INST_W-1:0]  r_illegal_pc;

    logic               w_lut_hit;
    micro_cmd_t         w_lut_micro;
    logic               w_hit;
    logic               w_accept;
    logic               w_accept_hit;
    logic               w_accept_miss;

    micro_lut u_lut (
        .i_key   ({in_inst[14:12], in_inst[6:2]}),
        .o_hit   (w_lut_hit),
        .o_micro (w_lut_micro)
    );

    // Only 32-bit encodings (bits[1:0] == 2'b11) may hit.
    assign w_hit         = w_lut_hit && (in_inst[1:0] == 2'b11);
    assign in_ready      = (r_state == StRun) && !flush && (!r_out_valid || out_ready);
    assign w_accept      = in_valid && in_ready;
    assign w_accept_hit  = w_accept && w_hit;
    assign w_accept_miss = w_accept && !w_hit;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StRun:   if (w_accept_miss) w_state_d = StHalt;
            StHalt:  w_state_d = StHalt;
            default: w_state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Output register: flush wins, then a new hit, then drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_micro <= '0;
            r_out_inst  <= '0;
            r_out_pc    <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept_hit) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept_hit) begin
                r_out_micro <= w_lut_micro;
                r_out_inst  <= in_inst;
                r_out_pc    <= in_pc;
            end
        end
    end

    // Trap capture; frozen after the first illegal instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal      <= 1'b0;
            r_illegal_inst <= '0;
            r_illegal_pc   <= '0;
        end else if (w_accept_miss && !r_illegal) begin
            r_illegal      <= 1'b1;
            r_illegal_inst <= in_inst;
            r_illegal_pc   <= in_pc;
        end
    end

`ifdef MICRO_DECODE_PERF_EN
    logic [CNT_W-1:0] r_perf_decoded;
    logic [CNT_W-1:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_decoded <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_accept_hit) begin
                r_perf_decoded <= r_perf_decoded + 1'b1;
            end
            if (in_valid && !in_ready && (r_state == StRun)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign perf_decoded = r_perf_decoded;
    assign perf_stall   = r_perf_stall;
`else
    assign perf_decoded = '0;
    assign perf_stall   = '0;
`endif

    assign out_valid    = r_out_valid;
    assign out_micro    = r_out_micro;
    assign out_inst     = r_out_inst;
    assign out_pc       = r_out_pc;
    assign illegal      = r_illegal;
    assign illegal_inst = r_illegal_inst;
    assign illegal_pc   = r_illegal_pc;
    assign halted       = (r_state == StHalt);

endmodule

// File: tb/tb_micro_decode_stage.sv
// tb_micro_decode_stage
// Scoreboard bench: a reference model pushes expected micro commands on every accepted
// transfer; a separate monitor pops and compares whenever the stage hands one to EXU.
module tb_micro_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_micro;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        illegal;
    logic [31:0] illegal_inst;
    logic [31:0] illegal_pc;
    logic        halted;
    logic [31:0] perf_decoded;
    logic [31:0] perf_stall;

    int n_tests = 0;
    int n_fail  = 0;

    micro_decode_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_micro    (out_micro),
        .out_inst     (out_inst),
        .out_pc       (out_pc),
        .illegal      (illegal),
        .illegal_inst (illegal_inst),
        .illegal_pc   (illegal_pc),
        .halted       (halted),
        .perf_decoded (perf_decoded),
        .perf_stall   (perf_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the instruction-set view: {hit, micro}.
    function automatic logic [10:0] ref_decode(input logic [31:0] inst);
        logic [2:0] f3;
        f3 = inst[14:12];
        if (inst[1:0] != 2'b11) return 11'd0;
        case (inst[6:2])
            5'b00101: return {1'b1, 10'b1010000110};
            5'b11011: return {1'b1, 10'b1110000111};
            5'b11001: return {1'b1, 10'b1100000001};
            5'b00000: begin
                if (f3 == 3'd0) return {1'b1, 10'b1000001001};
                if (f3 == 3'd1) return {1'b1, 10'b1000010001};
                if (f3 == 3'd2) return {1'b1, 10'b1000011001};
                return 11'd0;
            end
            5'b01000: return (f3 == 3'd2) ? {1'b1, 10'b0001100010} : 11'd0;
            5'b00100: return (f3 == 3'd0) ? {1'b1, 10'b1000000001} : 11'd0;
            5'b11100: return (f3 == 3'd0) ? {1'b1, 10'b0000000000} : 11'd0;
            default:  return 11'd0;
        endcase
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [9:0]  micro;
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    bit          m_full, m_halted, m_illegal;
    logic [31:0] m_ii, m_ip;
    int unsigned m_dec, m_stall;

    always @(negedge clk) begin
        logic [10:0] d;
        logic        exp_ready;
        logic        acc;
        exp_t        e;
        if (rst) begin
            m_full = 0; m_halted = 0; m_illegal = 0;
            m_ii = '0; m_ip = '0; m_dec = 0; m_stall = 0;
            sb.delete();
        end else begin
            exp_ready = !m_halted && !flush && (!m_full || out_ready);
            check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_full});
            check("halted", {31'd0, halted}, {31'd0, m_halted});
            check("illegal", {31'd0, illegal}, {31'd0, m_illegal});
            check("illegal_inst", illegal_inst, m_ii);
            check("illegal_pc", illegal_pc, m_ip);
`ifdef MICRO_DECODE_PERF_EN
            check("perf_decoded", perf_decoded, m_dec);
            check("perf_stall", perf_stall, m_stall);
`else
            check("perf_decoded", perf_decoded, 32'd0);
            check("perf_stall", perf_stall, 32'd0);
`endif
            d   = ref_decode(in_inst);
            acc = in_valid && exp_ready;
            if (in_valid && !exp_ready && !m_halted) m_stall++;
            if (flush) begin
                m_full = 0;
            end else if (acc) begin
                if (d[10]) begin
                    m_full = 1;
                    e.micro = d[9:0]; e.inst = in_inst; e.pc = in_pc;
                    sb.push_back(e);
                    m_dec++;
                end else begin
                    m_full = 0;
                    if (!m_illegal) begin
                        m_ii = in_inst;
                        m_ip = in_pc;
                    end
                    m_illegal = 1;
                    m_halted  = 1;
                end
            end else if (out_ready) begin
                m_full = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    bit          p_hold;
    logic [9:0]  p_micro;
    logic [31:0] p_inst, p_pc;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            p_hold = 0;
        end else begin
            if (p_hold) begin
                check("hold_micro", {22'd0, out_micro}, {22'd0, p_micro});
                check("hold_inst", out_inst, p_inst);
                check("hold_pc", out_pc, p_pc);
            end
            if (out_valid === 1'b1 && (flush || out_ready)) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    if (!flush) begin
                        check("out_micro", {22'd0, out_micro}, {22'd0, e.micro});
                        check("out_inst", out_inst, e.inst);
                        check("out_pc", out_pc, e.pc);
                    end
                end
            end
            p_hold  = (out_valid === 1'b1) && !out_ready && !flush;
            p_micro = out_micro;
            p_inst  = out_inst;
            p_pc    = out_pc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        rst = 1'b0; in_valid = v; in_inst = inst; in_pc = pc;
        out_ready = ordy; flush = fl;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_legal();
        logic [4:0]  ops [9];
        logic [2:0]  f3s [9];
        logic [31:0] w;
        int          k;
        ops = '{5'b00101, 5'b11011, 5'b11001, 5'b00000, 5'b00000, 5'b00000,
                5'b01000, 5'b00100, 5'b11100};
        f3s = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd0, 3'd0};
        k = $urandom_range(0, 8);
        w = $urandom;
        w[6:0] = {ops[k], 2'b11};
        if (k >= 3) w[14:12] = f3s[k];
        return w;
    endfunction

    initial begin
        logic [31:0] w;
        do_reset();
        do_reset();

        // Basic decode
        step(1, 32'h00500093, 32'h0000_0100, 1, 0);
        step(0, 0, 0, 1, 0);

        // Back-to-back stream
        step(1, 32'h0000A103, 32'h0000_0200, 1, 0);
        step(1, 32'h008000EF, 32'h0000_0204, 1, 0);
        step(1, 32'h0020A223, 32'h0000_0208, 1, 0);
        step(0, 0, 0, 1, 0);

        // Backpressure then simultaneous drain and accept
        step(1, 32'h00500093, 32'h0000_0300, 1, 0);
        repeat (3) step(1, 32'h0000A103, 32'h0000_0304, 0, 0);
        step(1, 32'h0000A103, 32'h0000_0304, 1, 0);
        step(0, 0, 0, 1, 0);

        // Illegal instruction traps and freezes intake
        step(1, 32'h00000033, 32'h8000_0010, 1, 0);
        repeat (3) step(1, 32'h00500093, 32'h8000_0014, 1, 0);
        step(1, 32'h00000013, 32'h8000_0018, 1, 0);

        // Reset out of HALT
        do_reset();
        step(0, 0, 0, 1, 0);

        // Flush with a held entry and a pending input
        step(1, 32'h00500093, 32'h0000_0400, 0, 0);
        step(1, 32'h0000A103, 32'h0000_0404, 0, 1);
        step(0, 0, 0, 0, 0);
        // Compressed-quadrant encoding traps
        step(1, 32'h00500090, 32'h0000_0408, 1, 0);
        step(1, 32'h00500093, 32'h0000_040C, 1, 0);
        do_reset();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_halted && ($urandom_range(0, 7) == 0)) begin
                do_reset();
            end else begin
                w = ($urandom_range(0, 39) == 0) ? $urandom : rand_legal();
                step($urandom_range(0, 3) != 0, w, $urandom,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            end
        end
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
